// File: rtl/arbitro_rr_vc.sv
// Round-robin scheduler from four first-word-fall-through input VC FIFOs to
// four output FIFOs, with per-destination packet counters readable via req/idx.
module arbitro_rr_vc #(
    parameter int TAMANO_DATOS = 12,
    parameter int CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              empty,
    input  logic [3:0]              almost_full,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    output logic [3:0]              pop,
    output logic [3:0]              push,
    output logic [TAMANO_DATOS-1:0] data_out,
    input  logic                    req,
    input  logic [1:0]              idx,
    output logic [CNT_W-1:0]        cnt_out,
    output logic                    cnt_valid,
    output logic                    idle
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [3:0]              push_q, push_d;
    logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]        count_q [4];
    logic [CNT_W-1:0]        count_d [4];
    logic [CNT_W-1:0]        cnt_out_q, cnt_out_d;
    logic                    cnt_valid_q, cnt_valid_d;

    logic [TAMANO_DATOS-1:0] head [4];
    logic [1:0]              dest [4];
    logic [3:0]              eligible;
    logic                    gnt_valid;
    logic [1:0]              gnt_idx;
    logic [1:0]              cand;

    // An input is eligible only if its own destination has room, so a blocked
    // head never stalls the other inputs.
    always_comb begin
        head[0] = data_in0;
        head[1] = data_in1;
        head[2] = data_in2;
        head[3] = data_in3;
        for (int i = 0; i < 4; i++) begin
            dest[i]     = head[i][TAMANO_DATOS-1 -: 2];
            eligible[i] = !empty[i] && !almost_full[dest[i]];
        end
    end

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (state_q != ST_ACTIVE) begin
            gnt_valid = 1'b0;
        end
    end

    assign pop = (gnt_valid && reset) ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!enable) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        ptr_d      = gnt_valid ? gnt_idx + 2'd1 : ptr_q;
        push_d     = gnt_valid ? (4'b0001 << dest[gnt_idx]) : 4'b0000;
        data_out_d = gnt_valid ? head[gnt_idx] : data_out_q;

        count_d = count_q;
        for (int d = 0; d < 4; d++) begin
            if (push_q[d]) begin
                count_d[d] = count_q[d] + CNT_W'(1);
            end
        end

        // Reads sample count_q, so a read racing an increment sees the old value.
        cnt_valid_d = req;
        cnt_out_d   = req ? count_q[idx] : cnt_out_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            push_q      <= 4'b0000;
            data_out_q  <= '0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            // NOTE: the counters are four small registers, not a RAM, so they
            // can and must clear on reset.
            for (int d = 0; d < 4; d++) begin
                count_q[d] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            push_q      <= push_d;
            data_out_q  <= data_out_d;
            cnt_out_q   <= cnt_out_d;
            cnt_valid_q <= cnt_valid_d;
            for (int d = 0; d < 4; d++) begin
                count_q[d] <= count_d[d];
            end
        end
    end

    assign push      = push_q;
    assign data_out  = data_out_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;
    assign idle      = (state_q == ST_IDLE) || ((&empty) && (push_q == 4'b0000));

endmodule
